// File: rtl/spi_flash_arbiter.sv
// Two-requester arbiter that frames flash READ transactions (cmd, 24-bit address, data bytes)
// onto a shared byte-level SPI engine: round-robin grant, CS-high gap, engine-stall watchdog.
module spi_flash_arbiter #(
    parameter int CS_GAP  = 4,
    parameter int TIMEOUT = 1024,
    parameter int LEN_W   = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [7:0]       cmd0,
    input  logic [7:0]       cmd1,
    input  logic [23:0]      addr0,
    input  logic [23:0]      addr1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             cs_n,
    output logic             eng_start,
    output logic [7:0]       eng_tx,
    input  logic             eng_done,
    input  logic [7:0]       eng_rx
);
    localparam int WD_W  = $clog2(TIMEOUT) + 1;
    localparam int GAP_W = $clog2(CS_GAP) + 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;
    logic             first_q, first_d;
    logic             busy_q, busy_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d, err_q, err_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             cs_n_q, cs_n_d;
    logic             eng_start_q, eng_start_d;
    logic [7:0]       eng_tx_q, eng_tx_d;

    logic             issue, finish, abort;
    logic [7:0]       issue_byte;
    logic             done_ok, timeout;

    // A done pulse only counts while a byte is outstanding; stray pulses are dropped here.
    assign done_ok = eng_done && busy_q;
    assign timeout = busy_q && !eng_done && (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        first_d     = first_q;
        busy_d      = busy_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wd_d        = wd_q;
        gap_d       = gap_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        rd_data_d   = rd_data_q;
        cs_n_d      = cs_n_q;
        eng_tx_d    = eng_tx_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err_d       = 1'b0;
        rd_valid_d  = 1'b0;
        eng_start_d = 1'b0;
        issue       = 1'b0;
        issue_byte  = 8'h00;
        finish      = 1'b0;
        abort       = 1'b0;

        if (busy_q && !eng_done) wd_d = wd_q + WD_W'(1);
        if (done_ok) busy_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = (req0 && req1) ? rr_q : req1;
                    cmd_d   = owner_d ? cmd1 : cmd0;
                    addr_d  = owner_d ? addr1 : addr0;
                    len_d   = owner_d ? len1 : len0;
                    gnt0_d  = ~owner_d;
                    gnt1_d  = owner_d;
                    cs_n_d  = 1'b0;
                    first_d = 1'b1;
                    state_d = CMD;
                end
            end
            CMD: begin
                // The grant cycle is CS setup time; the command byte goes out one cycle later.
                if (first_q) begin
                    first_d    = 1'b0;
                    issue      = 1'b1;
                    issue_byte = cmd_q;
                end else if (done_ok) begin
                    state_d    = ADDR;
                    idx_d      = 2'd0;
                    issue      = 1'b1;
                    issue_byte = addr_q[23:16];
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            ADDR: begin
                if (done_ok) begin
                    if (idx_q == 2'd2) begin
                        if (len_q == '0) begin
                            finish = 1'b1;
                        end else begin
                            state_d    = DATA;
                            cnt_d      = '0;
                            issue      = 1'b1;
                            issue_byte = 8'h00;
                        end
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        issue      = 1'b1;
                        issue_byte = (idx_q == 2'd0) ? addr_q[15:8] : addr_q[7:0];
                    end
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            DATA: begin
                if (done_ok) begin
                    rd_data_d  = eng_rx;
                    rd_valid_d = 1'b1;
                    cnt_d      = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        finish = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        issue_byte = 8'h00;
                    end
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(CS_GAP - 1)) begin
                    state_d = IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    rr_d    = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            eng_start_d = 1'b1;
            eng_tx_d    = issue_byte;
            busy_d      = 1'b1;
            wd_d        = '0;
        end

        if (finish || abort) begin
            state_d = GAP;
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
            gap_d   = '0;
            done0_d = ~owner_q;
            done1_d = owner_q;
            err_d   = abort;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            wd_q        <= '0;
            gap_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            cs_n_q      <= 1'b1;
            eng_start_q <= 1'b0;
            eng_tx_q    <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge _d values.
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            first_q     <= first_d;
            busy_q      <= busy_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            gap_q       <= gap_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            cs_n_q      <= cs_n_d;
            eng_start_q <= eng_start_d;
            eng_tx_q    <= eng_tx_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err       = err_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign cs_n      = cs_n_q;
    assign eng_start = eng_start_q;
    assign eng_tx    = eng_tx_q;

endmodule
